apb_slave_model: RTL and testbench

Synthesizable APB responder for the AHB-to-APB bridge environment. It sits on the APB side of the bridge and answers the bridge's `pselx`/`penable`/`pwrite`/`paddr`/`pwdata` transfers with real storage and read data. It provides three independent 16-word register banks, one per `pselx` line. A protocol-tracking FSM commits only legal SETUP→ACCESS transfers and latches the first protocol violation, so benches can run end-to-end data checks through the bridge.

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_reg_bank.sv | 32 +++
 rtl/apb_slave_model.sv | 155 +++++++++++++++
 tb/tb_apb_slave_model.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB slave model
//
// Purpose: FSM state encoding, error codes, bank count and select decode
//          helpers shared by apb_slave_model and its sub-modules.
// Ports:   none (package).
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NO_SETUP = 2'd1;
  localparam logic [1:0] ERR_SETUP    = 2'd2;
  localparam logic [1:0] ERR_SEL      = 2'd3;

  localparam int NUM_BANKS = 3;

  // True when two or more select lines are active at once.
  function automatic logic sel_multi(input logic [2:0] sel);
    return (sel & (sel - 3'd1)) != 3'd0;
  endfunction

  // Bank index of a one-hot select; only meaningful when exactly one bit is set.
  function automatic logic [1:0] sel_index(input logic [2:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    if (sel[1]) idx = 2'd1;
    if (sel[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - one register bank with a write port and a read port
//
// Purpose: WORDS x 32 storage cleared by synchronous reset.
// Ports:   hclk, hreset  clock and synchronous active-high reset
//          we, waddr, wdata  write port (committed on the rising edge)
//          raddr, rdata      combinational read port
module apb_reg_bank #(
  parameter int WORDS = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < WORDS)) begin
      mem[waddr] <= wdata;
    end
  end

  // Indices beyond the populated words read as zero.
  assign rdata = (int'(raddr) < WORDS) ? mem[raddr] : '0;

endmodule

// File: rtl/apb_slave_model.sv
// rtl/apb_slave_model.sv - APB responder with three register banks and protocol checking
//
// Purpose: answers APB transfers from the bridge with real storage, commits only
//          legal SETUP->ACCESS transfers and latches the first protocol violation.
// Ports:   hclk, hreset                clock, synchronous active-high reset
//          pselx, penable, pwrite      APB control (pselx one-hot, bit n = bank n)
//          paddr, pwdata               byte address (bits [5:2] index) and write data
//          prdata                      registered read data, valid in ACCESS
//          perr, err_code              sticky violation flag and first violation code
//          wr_count, rd_count          committed transfer counters (wrapping)
module apb_slave_model
  import apb_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int CNT_W = 16
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [2:0]       pselx,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [31:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             perr,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  apb_state_t  state;
  apb_state_t  next_state;
  logic [31:0] snap_addr;
  logic        snap_write;
  logic [2:0]  snap_sel;

  logic        psel;
  logic        multi;
  logic [3:0]  idx;
  logic        match;
  logic        commit;
  logic        start;
  logic        viol;
  logic [1:0]  viol_code;
  logic [31:0] pf_data;
  logic [31:0] bank_rd [NUM_BANKS];

  assign psel   = |pselx;
  assign multi  = sel_multi(pselx);
  assign idx    = paddr[5:2];
  assign match  = (paddr == snap_addr) && (pwrite == snap_write) && (pselx == snap_sel);
  // A multi-select cycle can never match the one-hot snapshot, so it never commits.
  assign commit = (state == ST_SETUP) && psel && penable && match;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    apb_reg_bank #(.WORDS(WORDS)) u_bank (
      .hclk  (hclk),
      .hreset(hreset),
      .we    (commit && snap_write && snap_sel[b]),
      .waddr (idx),
      .wdata (pwdata),
      .raddr (idx),
      .rdata (bank_rd[b])
    );
  end

  always_comb begin
    pf_data = bank_rd[0];
    case (sel_index(pselx))
      2'd1:    pf_data = bank_rd[1];
      2'd2:    pf_data = bank_rd[2];
      default: pf_data = bank_rd[0];
    endcase
  end

  // Multi-select overrides every other transition, which also makes code 3
  // win over a simultaneous enable-without-setup.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    viol       = 1'b0;
    viol_code  = ERR_NONE;
    if (multi) begin
      viol       = 1'b1;
      viol_code  = ERR_SEL;
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && penable) begin
            viol      = 1'b1;
            viol_code = ERR_NO_SETUP;
          end else if (psel) begin
            start      = 1'b1;
            next_state = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (commit) begin
            next_state = ST_ACCESS;
          end else begin
            viol       = 1'b1;
            viol_code  = ERR_SETUP;
            next_state = ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            next_state = ST_IDLE;
          end else if (!penable) begin
            start      = 1'b1;
            next_state = ST_SETUP;
          end else begin
            viol       = 1'b1;
            viol_code  = ERR_NO_SETUP;
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      snap_addr  <= '0;
      snap_write <= 1'b0;
      snap_sel   <= '0;
      prdata     <= '0;
      perr       <= 1'b0;
      err_code   <= ERR_NONE;
      wr_count   <= '0;
      rd_count   <= '0;
    end else begin
      state <= next_state;
      if (viol && !perr) begin
        perr     <= 1'b1;
        err_code <= viol_code;
      end
      if (start) begin
        snap_addr  <= paddr;
        snap_write <= pwrite;
        snap_sel   <= pselx;
        // Bank write from the previous ACCESS edge is already visible here.
        if (!pwrite) prdata <= pf_data;
      end
      if (commit) begin
        if (snap_write) wr_count <= wr_count + CNT_W'(1);
        else            rd_count <= rd_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_model.sv
// tb/tb_apb_slave_model.sv - scoreboard testbench for apb_slave_model
module tb_apb_slave_model;
  localparam int CNT_W = 16;

  localparam int K_PRDATA = 0;
  localparam int K_PERR   = 1;
  localparam int K_CODE   = 2;
  localparam int K_WR     = 3;
  localparam int K_RD     = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic             hclk = 1'b0;
  logic             hreset = 1'b1;
  logic [2:0]       pselx = '0;
  logic             penable = 1'b0;
  logic             pwrite = 1'b0;
  logic [31:0]      paddr = '0;
  logic [31:0]      pwdata = '0;
  logic [31:0]      prdata;
  logic             perr;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] rd_count;

  exp_t exp_q[$];
  int   pending_n = 0;
  int   sample_n = 0;
  int   checks = 0;
  int   errors = 0;

  apb_slave_model #(.WORDS(16), .CNT_W(CNT_W)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .perr    (perr),
    .err_code(err_code),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  always #5 hclk = ~hclk;

  // Monitor: pops and compares the expectations tagged for this cycle.
  always @(negedge hclk) begin
    if (sample_n > 0) begin
      for (int i = 0; i < sample_n; i++) begin
        exp_t e;
        logic [31:0] act;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow got empty queue want entry");
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            K_PRDATA: act = prdata;
            K_PERR:   act = {31'd0, perr};
            K_CODE:   act = {30'd0, err_code};
            K_WR:     act = {16'd0, wr_count};
            default:  act = {16'd0, rd_count};
          endcase
          if (act !== e.val) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, act, e.val);
          end
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
    pending_n++;
  endtask

  task automatic cyc(input logic [2:0] sel, input logic en, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    pselx    = sel;
    penable  = en;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = data;
    sample_n = pending_n;
    pending_n = 0;
    @(posedge hclk);
    #1;
    sample_n = 0;
  endtask

  task automatic idle();
    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    idle();
    idle();
    hreset = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
    cyc(sel, 1'b0, 1'b1, addr, data);
    cyc(sel, 1'b1, 1'b1, addr, data);
  endtask

  task automatic apb_read(input string name, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] exp_data);
    cyc(sel, 1'b0, 1'b0, addr, 32'h0);
    expect_val(name, K_PRDATA, exp_data);
    cyc(sel, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic check_status(input string tag, input logic p, input logic [1:0] c,
                              input int wr, input int rd);
    expect_val({tag, "_perr"}, K_PERR, {31'd0, p});
    expect_val({tag, "_err_code"}, K_CODE, {30'd0, c});
    expect_val({tag, "_wr_count"}, K_WR, wr);
    expect_val({tag, "_rd_count"}, K_RD, rd);
    idle();
  endtask

  initial begin
    @(posedge hclk);
    #1;

    // Reset state and a read of untouched storage.
    do_reset();
    expect_val("reset_prdata", K_PRDATA, 32'h0);
    check_status("reset", 1'b0, 2'd0, 0, 0);
    apb_read("reset_read_b1_i5", 3'b010, 32'h14, 32'h0);

    // Single write then back-to-back read of the same location.
    do_reset();
    apb_write(3'b010, 32'h14, 32'hDEADBEEF);
    apb_read("wr_rd_b1_i5", 3'b010, 32'h14, 32'hDEADBEEF);
    check_status("wr_rd", 1'b0, 2'd0, 1, 1);
    apb_read("other_bank0_i5", 3'b001, 32'h14, 32'h0);
    apb_read("other_bank2_i5", 3'b100, 32'h14, 32'h0);

    // Back-to-back burst of writes then reads with no idle cycles.
    do_reset();
    for (int i = 0; i < 8; i++) apb_write(3'b001, 32'(i * 4), 32'(16 + i));
    for (int i = 0; i < 8; i++) apb_read($sformatf("burst_rd_%0d", i), 3'b001, 32'(i * 4), 32'(16 + i));
    check_status("burst", 1'b0, 2'd0, 8, 8);

    // Enable without setup, then a later multi-select must not change the code.
    do_reset();
    cyc(3'b001, 1'b1, 1'b1, 32'h0, 32'h55);
    idle();
    check_status("no_setup", 1'b1, 2'd1, 0, 0);
    cyc(3'b011, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    check_status("sticky", 1'b1, 2'd1, 0, 0);
    apb_read("no_setup_not_written", 3'b001, 32'h0, 32'h0);

    // Address changes between SETUP and ACCESS.
    do_reset();
    cyc(3'b001, 1'b0, 1'b1, 32'h08, 32'h77);
    cyc(3'b001, 1'b1, 1'b1, 32'h0C, 32'h77);
    idle();
    check_status("setup_broken", 1'b1, 2'd2, 0, 0);
    apb_read("setup_broken_i2", 3'b001, 32'h08, 32'h0);
    apb_read("setup_broken_i3", 3'b001, 32'h0C, 32'h0);

    // Multi-select together with enable-without-setup: code 3 wins.
    do_reset();
    cyc(3'b011, 1'b1, 1'b1, 32'h0, 32'h0);
    idle();
    check_status("sel_wins", 1'b1, 2'd3, 0, 0);

    // Reset during the ACCESS cycle of a write drops it.
    do_reset();
    apb_write(3'b100, 32'h04, 32'h1234);
    apb_read("pre_rst_fill", 3'b100, 32'h04, 32'h1234);
    cyc(3'b001, 1'b0, 1'b1, 32'h10, 32'h99);
    hreset = 1'b1;
    cyc(3'b001, 1'b1, 1'b1, 32'h10, 32'h99);
    hreset = 1'b0;
    expect_val("mid_rst_prdata", K_PRDATA, 32'h0);
    check_status("mid_rst", 1'b0, 2'd0, 0, 0);
    apb_read("mid_rst_i4", 3'b001, 32'h10, 32'h0);
    apb_read("mid_rst_bank2", 3'b100, 32'h04, 32'h0);

    idle();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
